// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
//   Shares one asynchronous SRAM frame buffer between VGA scan-out and a single
//   pixel writer. Scan-out words (two RGB332 pixels each) are prefetched into a
//   small FIFO and unpacked on i_pix_req; every SRAM cycle not needed for
//   prefetch is granted to the writer.
//
// Ports
//   i_clk, i_rst_n                 pixel clock, asynchronous active-low reset
//   i_frame_start                  restart scan-out at word 0 (flushes FIFO)
//   i_pix_req                      consume one pixel this cycle
//   o_pix_rgb                      registered RGB332 pixel, valid the cycle after i_pix_req
//   o_underflow                    sticky: pixel requested while FIFO empty
//   i_wr_req/i_wr_addr/i_wr_data   writer request, held until o_wr_ack
//   o_wr_ack                       combinational grant, write taken on this edge
//   o_sram_*                       registered SRAM control / address / write data
//   i_sram_dq_in                   SRAM read data
module vga_fb_arbiter #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_W     = 20
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_frame_start,
  input  logic              i_pix_req,
  output logic [7:0]        o_pix_rgb,
  output logic              o_underflow,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [15:0]       i_wr_data,
  output logic              o_wr_ack,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [15:0]       o_sram_dq_out,
  output logic              o_sram_dq_oe,
  input  logic [15:0]       i_sram_dq_in,
  output logic              o_sram_ce_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n,
  output logic              o_sram_lb_n,
  output logic              o_sram_ub_n
);

  localparam int unsigned FRAME_WORDS = (H_ACTIVE * V_ACTIVE) / 2;
  localparam int unsigned PTR_W       = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W       = PTR_W + 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);
  localparam logic [CNT_W:0]    DEPTH_C   = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_W-1:0] r_rd_addr;
  logic [1:0]        r_inflight;
  logic              r_rd_pend;

  logic [15:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_phase;

  logic [7:0]        r_pix_rgb;
  logic              r_underflow;

  logic [ADDR_W-1:0] r_sram_addr;
  logic [15:0]       r_sram_dq_out;
  logic              r_sram_dq_oe;
  logic              r_sram_ce_n;
  logic              r_sram_oe_n;
  logic              r_sram_we_n;

  logic [CNT_W:0]    w_occupancy;
  logic              w_rd_slot;
  logic              w_wr_slot;
  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic [15:0]       w_head;

  // ---------------------------------------------------------------------------
  // Slot arbitration: prefetch has strict priority while the FIFO (including
  // reads already issued) has room. No read is issued on a frame_start cycle so
  // the new frame always begins cleanly at word 0.
  // ---------------------------------------------------------------------------
  assign w_occupancy = {1'b0, r_count} + (CNT_W + 1)'(r_inflight);
  assign w_rd_slot   = (r_state == ST_FETCH) && !i_frame_start && (w_occupancy < DEPTH_C);
  assign w_wr_slot   = i_rst_n && !w_rd_slot && i_wr_req;
  assign o_wr_ack    = w_wr_slot;

  assign w_empty = (r_count == '0);
  assign w_head  = r_mem[r_rd_ptr];

  // A read on the pins this cycle lands at the coming edge. On a frame_start
  // edge it belongs to the old frame and is discarded together with the flush;
  // since at most one read is ever in flight, this covers every stale read.
  assign w_push = r_rd_pend && !i_frame_start;
  assign w_pop  = i_pix_req && !i_frame_start && !w_empty && r_phase;

  // ---------------------------------------------------------------------------
  // Reader FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_frame_start) w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (i_frame_start) begin
          w_state_nxt = ST_FETCH;
        end else if (w_rd_slot && (r_rd_addr == LAST_ADDR)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (i_frame_start) w_state_nxt = ST_FETCH;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read address and in-flight tracking
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_addr  <= '0;
      r_inflight <= '0;
      r_rd_pend  <= 1'b0;
    end else begin
      r_rd_pend <= w_rd_slot;
      if (i_frame_start) begin
        r_rd_addr  <= '0;
        r_inflight <= '0;
      end else begin
        if (w_rd_slot && (r_rd_addr != LAST_ADDR)) begin
          r_rd_addr <= r_rd_addr + 1'b1;
        end
        case ({w_rd_slot, r_rd_pend})
          2'b10:   r_inflight <= r_inflight + 1'b1;
          2'b01:   r_inflight <= r_inflight - 1'b1;
          default: r_inflight <= r_inflight;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Prefetch FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_sram_dq_in;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_frame_start) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel unpacking: high byte first, word popped after its low byte.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pix_rgb   <= '0;
      r_underflow <= 1'b0;
      r_phase     <= 1'b0;
    end else if (i_frame_start) begin
      r_phase <= 1'b0;
      if (i_pix_req) r_pix_rgb <= '0;
    end else if (i_pix_req) begin
      if (w_empty) begin
        r_pix_rgb   <= '0;
        r_underflow <= 1'b1;
      end else if (!r_phase) begin
        r_pix_rgb <= w_head[15:8];
        r_phase   <= 1'b1;
      end else begin
        r_pix_rgb <= w_head[7:0];
        r_phase   <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // SRAM pin registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sram_addr   <= '0;
      r_sram_dq_out <= '0;
      r_sram_dq_oe  <= 1'b0;
      r_sram_ce_n   <= 1'b1;
      r_sram_oe_n   <= 1'b1;
      r_sram_we_n   <= 1'b1;
    end else if (w_rd_slot) begin
      r_sram_addr   <= r_rd_addr;
      r_sram_dq_oe  <= 1'b0;
      r_sram_ce_n   <= 1'b0;
      r_sram_oe_n   <= 1'b0;
      r_sram_we_n   <= 1'b1;
    end else if (w_wr_slot) begin
      r_sram_addr   <= i_wr_addr;
      r_sram_dq_out <= i_wr_data;
      r_sram_dq_oe  <= 1'b1;
      r_sram_ce_n   <= 1'b0;
      r_sram_oe_n   <= 1'b1;
      r_sram_we_n   <= 1'b0;
    end else begin
      r_sram_dq_oe  <= 1'b0;
      r_sram_ce_n   <= 1'b1;
      r_sram_oe_n   <= 1'b1;
      r_sram_we_n   <= 1'b1;
    end
  end

  assign o_pix_rgb     = r_pix_rgb;
  assign o_underflow   = r_underflow;
  assign o_sram_addr   = r_sram_addr;
  assign o_sram_dq_out = r_sram_dq_out;
  assign o_sram_dq_oe  = r_sram_dq_oe;
  assign o_sram_ce_n   = r_sram_ce_n;
  assign o_sram_oe_n   = r_sram_oe_n;
  assign o_sram_we_n   = r_sram_we_n;
  assign o_sram_lb_n   = 1'b0;
  assign o_sram_ub_n   = 1'b0;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter using a reduced 16x4 frame (32 words).
module tb_vga_fb_arbiter;

  localparam int unsigned AW = 20;
  localparam int unsigned FW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          frame_start = 1'b0;
  logic          pix_req = 1'b0;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [15:0]   wr_data = '0;

  logic [7:0]    pix_rgb;
  logic          underflow;
  logic          wr_ack;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out;
  logic          sram_dq_oe;
  logic [15:0]   sram_dq_in;
  logic          ce_n, oe_n, we_n, lb_n, ub_n;

  int checks = 0;
  int failures = 0;

  logic [7:0]    exp_q[$];
  logic [AW-1:0] exp_ra = '0;
  logic [AW-1:0] last_ra = '0;
  int            rd_cnt = 0;

  vga_fb_arbiter #(
    .H_ACTIVE  (16),
    .V_ACTIVE  (4),
    .FIFO_DEPTH(8),
    .ADDR_W    (AW)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_frame_start(frame_start),
    .i_pix_req    (pix_req),
    .o_pix_rgb    (pix_rgb),
    .o_underflow  (underflow),
    .i_wr_req     (wr_req),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .o_wr_ack     (wr_ack),
    .o_sram_addr  (sram_addr),
    .o_sram_dq_out(sram_dq_out),
    .o_sram_dq_oe (sram_dq_oe),
    .i_sram_dq_in (sram_dq_in),
    .o_sram_ce_n  (ce_n),
    .o_sram_oe_n  (oe_n),
    .o_sram_we_n  (we_n),
    .o_sram_lb_n  (lb_n),
    .o_sram_ub_n  (ub_n)
  );

  always #5 clk = ~clk;

  // Frame buffer contents seen by scan-out.
  function automatic logic [15:0] fw(input int k);
    logic [7:0] b;
    b = 8'(k);
    if (k == 0) return 16'hE01C;
    if (k == 1) return 16'h03FF;
    return {b ^ 8'hA5, b + 8'h3C};
  endfunction

  function automatic logic [7:0] exp_pix(input int p);
    logic [15:0] w;
    w = fw(p / 2);
    return (p % 2 == 0) ? w[15:8] : w[7:0];
  endfunction

  always_comb begin
    sram_dq_in = (!ce_n && !oe_n) ? fw(int'(sram_addr)) : 16'hDEAD;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [7:0] e);
    pix_req = 1'b1;
    exp_q.push_back(e);
    tick();
    pix_req = 1'b0;
  endtask

  task automatic fs_pulse;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    exp_ra = '0;
    rd_cnt = 0;
  endtask

  // Pixel scoreboard: output is due the cycle after a sampled request.
  initial begin
    logic prev_req;
    logic [7:0] e;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_req) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pix_unexpected actual=%0h required=none", pix_rgb);
        end else begin
          e = exp_q.pop_front();
          chk("pix", 32'(pix_rgb), 32'(e));
        end
      end
      prev_req = pix_req;
    end
  end

  // Read-slot monitor: scan-out addresses must be sequential from 0.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && !ce_n && !oe_n) begin
        chk("rd_addr", 32'(sram_addr), 32'(exp_ra));
        last_ra = sram_addr;
        exp_ra  = exp_ra + 1'b1;
        rd_cnt++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int p;
    logic a, prev_a;

    #2 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_ce_n", 32'(ce_n), 1);
    chk("rst_oe_n", 32'(oe_n), 1);
    chk("rst_we_n", 32'(we_n), 1);
    chk("rst_dq_oe", 32'(sram_dq_oe), 0);
    chk("rst_lb_ub", 32'({lb_n, ub_n}), 0);
    chk("rst_addr", 32'(sram_addr), 0);
    chk("rst_dq_out", 32'(sram_dq_out), 0);
    chk("rst_pix", 32'(pix_rgb), 0);
    chk("rst_uf", 32'(underflow), 0);
    chk("rst_ack", 32'(wr_ack), 0);
    rst_n = 1'b1;
    tick();

    // Reset asserted mid-write.
    wr_req  = 1'b1;
    wr_addr = 20'h0002A;
    wr_data = 16'hBEEF;
    #1 chk("idle_ack", 32'(wr_ack), 1);
    tick();
    chk("wr_we_n", 32'(we_n), 0);
    chk("wr_oe_n", 32'(oe_n), 1);
    chk("wr_dq_oe", 32'(sram_dq_oe), 1);
    chk("wr_addr", 32'(sram_addr), 32'h2A);
    chk("wr_data", 32'(sram_dq_out), 32'hBEEF);
    wr_addr = 20'h0002B;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_we_n", 32'(we_n), 1);
    chk("midrst_dq_oe", 32'(sram_dq_oe), 0);
    chk("midrst_ce_n", 32'(ce_n), 1);
    chk("midrst_addr", 32'(sram_addr), 0);
    chk("midrst_dq_out", 32'(sram_dq_out), 0);
    chk("midrst_ack", 32'(wr_ack), 0);
    wr_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Pixel before any frame_start.
    pix(8'h00);
    chk("uf_set", 32'(underflow), 1);
    tick();
    chk("no_rd_idle", 32'(rd_cnt), 0);

    // Prefetch fills exactly FIFO_DEPTH words.
    fs_pulse();
    repeat (14) tick();
    chk("fill_reads", 32'(rd_cnt), 8);
    chk("fill_last", 32'(last_ra), 7);
    pix(8'hE0);
    pix(8'h1C);
    pix(8'h03);
    pix(8'hFF);
    p = 4;
    repeat (4) tick();

    // FIFO full: writer gets every cycle.
    wr_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_addr = AW'(40 + i);
      wr_data = 16'(16'h5A00 + i);
      #1 chk("full_ack", 32'(wr_ack), 1);
      tick();
      chk("full_wr_addr", 32'(sram_addr), 32'(40 + i));
      chk("full_wr_data", 32'(sram_dq_out), 32'(16'h5A00 + i));
      chk("full_we_n", 32'(we_n), 0);
    end

    // Steady drain, one pixel per cycle, writer still requesting.
    wr_addr = 20'd50;
    prev_a = 1'b1;
    for (int c = 0; c < 24; c++) begin
      pix_req = 1'b1;
      exp_q.push_back(exp_pix(p));
      p++;
      #1 a = wr_ack;
      chk("drain_ack_pair", 32'(a | prev_a), 1);
      prev_a = a;
      tick();
      if (a) wr_addr = wr_addr + 1'b1;
    end
    wr_req = 1'b0;

    // Remainder of the frame.
    while (p < 2 * FW) begin
      exp_q.push_back(exp_pix(p));
      p++;
      tick();
    end
    pix_req = 1'b0;
    repeat (3) tick();
    chk("frame_reads", 32'(rd_cnt), FW);
    chk("frame_last", 32'(last_ra), FW - 1);
    repeat (6) tick();
    chk("done_no_reads", 32'(rd_cnt), FW);
    pix(8'h00);

    // frame_start together with a pixel request.
    fs_pulse();
    repeat (12) tick();
    pix(8'hE0);
    frame_start = 1'b1;
    pix_req = 1'b1;
    exp_q.push_back(8'h00);
    tick();
    frame_start = 1'b0;
    exp_ra = '0;
    rd_cnt = 0;
    exp_q.push_back(8'h00);
    tick();
    pix_req = 1'b0;
    repeat (4) tick();
    pix(8'hE0);
    pix(8'h1C);

    // frame_start with a read on the pins.
    fs_pulse();
    tick();
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    exp_ra = '0;
    rd_cnt = 0;
    repeat (3) tick();
    for (int i = 0; i < 6; i++) pix(exp_pix(i));
    repeat (3) tick();

    chk("uf_sticky", 32'(underflow), 1);
    chk("sb_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
